demux_1x16_deser: RTL and testbench

DEMUX_1X16_DESER -- requirements
Module: demux_1x16_deser

---
 rtl/demux_1x16_deser.sv | 101 ++++++++++
 tb/tb_demux_1x16_deser.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x16_deser.sv
// Serial-to-parallel 1:16 demultiplexer with an assembly register and a one-word
// output register, so a stalled consumer costs at most one extra buffered word.
module demux_1x16_deser #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        clear,
    output logic [3:0]  select,
    output logic [15:0] out,
    output logic        out_valid,
    input  logic        out_ready
);

    logic [3:0]  select_reg, select_next;
    logic [15:0] asm_reg, asm_next;
    logic        asm_full_reg, asm_full_next;
    logic [15:0] out_reg, out_next;
    logic        out_valid_reg, out_valid_next;

    logic [3:0]  idx;
    logic [15:0] asm_with_bit;
    logic        slot_free;
    logic        accept;
    logic        word_done;
    logic        load_from_in;
    logic        load_from_asm;

    assign idx       = MSB_FIRST ? (4'd15 - select_reg) : select_reg;
    assign slot_free = !out_valid_reg || out_ready;
    assign accept    = in_valid && !asm_full_reg;
    assign word_done = accept && (select_reg == 4'd15);

    // The word including the bit being accepted this cycle.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_asm_bit
            assign asm_with_bit[gi] = (idx == 4'(gi)) ? in : asm_reg[gi];
        end
    endgenerate

    // clear wins over both the completing accept and the buffered transfer.
    assign load_from_in  = !clear && word_done && slot_free;
    assign load_from_asm = !clear && asm_full_reg && slot_free;

    always_comb begin
        select_next    = select_reg;
        asm_next       = asm_reg;
        asm_full_next  = asm_full_reg;
        out_next       = out_reg;
        out_valid_next = out_valid_reg;

        if (clear) begin
            select_next   = 4'd0;
            asm_next      = 16'h0000;
            asm_full_next = 1'b0;
        end else if (accept) begin
            asm_next    = asm_with_bit;
            select_next = select_reg + 4'd1;
            if (word_done && !slot_free) begin
                asm_full_next = 1'b1;
            end
        end else if (asm_full_reg && slot_free) begin
            asm_full_next = 1'b0;
        end

        if (load_from_in) begin
            out_next       = asm_with_bit;
            out_valid_next = 1'b1;
        end else if (load_from_asm) begin
            out_next       = asm_reg;
            out_valid_next = 1'b1;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            select_reg    <= 4'd0;
            asm_reg       <= 16'h0000;
            asm_full_reg  <= 1'b0;
            out_reg       <= 16'h0000;
            out_valid_reg <= 1'b0;
        end else begin
            select_reg    <= select_next;
            asm_reg       <= asm_next;
            asm_full_reg  <= asm_full_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign in_ready  = !asm_full_reg;
    assign select    = select_reg;
    assign out       = out_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_demux_1x16_deser.sv
// Bench for demux_1x16_deser: an LSB-first and an MSB-first instance share one
// input stream, so every word is checked in both bit orders.
module tb_demux_1x16_deser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_bit = 1'b0;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready0, in_ready1;
    logic [3:0]  select0, select1;
    logic [15:0] out0, out1;
    logic        out_valid0, out_valid1;

    int n_checks = 0;
    int n_fail   = 0;

    demux_1x16_deser #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in(in_bit), .in_valid(in_valid),
        .in_ready(in_ready0), .clear(clear), .select(select0), .out(out0),
        .out_valid(out_valid0), .out_ready(out_ready)
    );

    demux_1x16_deser #(.MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in(in_bit), .in_valid(in_valid),
        .in_ready(in_ready1), .clear(clear), .select(select1), .out(out1),
        .out_valid(out_valid1), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] data;   // bit k is the k-th bit sent
        int          gap;    // idle cycles before each odd-numbered bit
        logic [15:0] exp0;   // LSB-first result
        logic [15:0] exp1;   // MSB-first result
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = w[15 - i];
        return r;
    endfunction

    // Holds in_valid until the bit is taken; in_ready is stable between edges.
    task automatic send_bit(input logic b);
        int   n = 0;
        logic took = 1'b0;
        in_bit   = b;
        in_valid = 1'b1;
        while (!took && n < 64) begin
            took = in_ready0;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!took) chk("accept_timeout", 32'(took), 32'd1);
    endtask

    task automatic send_word(input logic [15:0] data, input int gap);
        logic [3:0] k4;
        for (int k = 0; k < 16; k++) begin
            if (gap > 0 && k[0]) begin
                repeat (gap) tick();
                k4 = 4'(k);
                chk("select_hold_lsb", 32'(select0), 32'(k4));
                chk("select_hold_msb", 32'(select1), 32'(k4));
            end
            send_bit(data[k]);
        end
    endtask

    vec_t        vecs[4];
    logic [15:0] sbq[$];
    logic [15:0] acc;
    logic [15:0] expw;
    int          bitcnt, words_in, words_out, cycles;

    initial begin
        vecs[0] = '{16'hAAAA, 0, 16'hAAAA, 16'h5555};
        vecs[1] = '{16'h2C48, 2, 16'h2C48, 16'h1234};
        vecs[2] = '{16'h000F, 1, 16'h000F, 16'hF000};
        vecs[3] = '{16'h8001, 0, 16'h8001, 16'h8001};

        // Reset values
        tick();
        chk("rst_select", 32'(select0), 32'd0);
        chk("rst_out", 32'(out0), 32'h0);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        rst_n = 1'b1;
        tick();

        // Table: free-flowing consumer, 1-cycle latency, then pop without reload
        for (int v = 0; v < 4; v++) begin
            out_ready = 1'b1;
            send_word(vecs[v].data, vecs[v].gap);
            chk("vec_out_valid", 32'(out_valid0), 32'd1);
            chk("vec_out_lsb", 32'(out0), 32'(vecs[v].exp0));
            chk("vec_out_msb", 32'(out1), 32'(vecs[v].exp1));
            chk("vec_select_wrap", 32'(select0), 32'd0);
            tick();
            chk("vec_pop_valid", 32'(out_valid0), 32'd0);
            chk("vec_pop_retain", 32'(out0), 32'(vecs[v].exp0));
            $display("vector %0d: sent %h -> lsb %h msb %h", v, vecs[v].data, out0, out1);
        end

        // Back-pressure: second word parks in asm, then moves in with no bubble
        out_ready = 1'b0;
        send_word(16'h00FF, 0);
        send_word(16'hFF00, 0);
        chk("bp_out_first", 32'(out0), 32'h00FF);
        chk("bp_out_first_msb", 32'(out1), 32'hFF00);
        chk("bp_in_ready_low", 32'(in_ready0), 32'd0);
        in_valid = 1'b1; in_bit = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_stalled_select", 32'(select0), 32'd0);
        chk("bp_still_full", 32'(in_ready0), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_transfer_out", 32'(out0), 32'hFF00);
        chk("bp_transfer_msb", 32'(out1), 32'h00FF);
        chk("bp_transfer_valid", 32'(out_valid0), 32'd1);
        chk("bp_in_ready_back", 32'(in_ready0), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_drained", 32'(out_valid0), 32'd0);
        $display("backpressure: 00FF then FF00 delivered, out %h", out0);

        // clear with a same-cycle bit: partial word and the bit are dropped
        for (int k = 0; k < 5; k++) send_bit(1'b1);
        in_valid = 1'b1; in_bit = 1'b1; clear = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b0;
        chk("clr_select", 32'(select0), 32'd0);
        send_word(16'hF0F0, 0);
        chk("clr_out_lsb", 32'(out0), 32'hF0F0);
        chk("clr_out_msb", 32'(out1), 32'h0F0F);
        tick();
        $display("clear: partial dropped, out %h", out0);

        // clear while a word is buffered discards it but leaves out alone
        out_ready = 1'b0;
        send_word(16'h1111, 0);
        send_word(16'h2222, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrfull_in_ready", 32'(in_ready0), 32'd1);
        chk("clrfull_out_kept", 32'(out0), 32'h1111);
        chk("clrfull_valid_kept", 32'(out_valid0), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("clrfull_discarded", 32'(out_valid0), 32'd0);
        chk("clrfull_retain", 32'(out0), 32'h1111);
        $display("clear while full: buffered word discarded, out %h", out0);

        // Reset mid-word
        for (int k = 0; k < 9; k++) send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_select", 32'(select0), 32'd0);
        chk("mid_rst_select_msb", 32'(select1), 32'd0);
        chk("mid_rst_out", 32'(out0), 32'h0);
        chk("mid_rst_valid", 32'(out_valid0), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready0), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        send_word(16'h5A5A, 0);
        chk("post_rst_lsb", 32'(out0), 32'h5A5A);
        chk("post_rst_msb", 32'(out1), 32'h5A5A);
        chk("post_rst_valid", 32'(out_valid0), 32'd1);
        tick();
        $display("reset mid-word: recovered, out %h", out0);

        // Random stress against a scoreboard
        acc = 16'h0; bitcnt = 0; words_in = 0; words_out = 0; cycles = 0;
        while (words_out < 1000 && cycles < 60000) begin
            in_valid  = (words_in < 1000) && ($urandom_range(0, 3) != 0);
            in_bit    = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid0 && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    expw = sbq.pop_front();
                    chk("sb_word_lsb", 32'(out0), 32'(expw));
                    chk("sb_word_msb", 32'(out1), 32'(rev16(expw)));
                    $display("stress word %0d: got %h expected %h", words_out, out0, expw);
                end
                words_out++;
            end
            if (in_valid && in_ready0) begin
                acc[bitcnt] = in_bit;
                bitcnt++;
                if (bitcnt == 16) begin
                    sbq.push_back(acc);
                    bitcnt = 0;
                    words_in++;
                end
            end
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        chk("sb_words_out", 32'(words_out), 32'd1000);
        chk("sb_queue_empty", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
